muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU. It takes the same decoded register operands the ALU takes. Its result is muxed with the ALU output before the EX/MEM latch. The pipeline hazard logic stalls while busy is high and advances on done.

---
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, with a
// single-cycle fast path for divide-by-zero and signed divide overflow.
module muldiv_unit #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WORD_W-1:0] port_a,
  input  logic [WORD_W-1:0] port_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic              div_zero,
  output logic [1:0]        dbg_state
);

  // Handshake: start is taken only in IDLE with flush low and no done pulse
  // showing; the matching result appears with the single-cycle done pulse.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [WORD_W-1:0]   W_ONE   = {{(WORD_W-1){1'b0}}, 1'b1};
  localparam logic [WORD_W-1:0]   W_ONES  = {WORD_W{1'b1}};
  localparam logic [WORD_W-1:0]   W_MIN   = {1'b1, {(WORD_W-1){1'b0}}};
  localparam logic [2*WORD_W-1:0] D_ONE   = {{WORD_W{1'b0}}, W_ONE};
  localparam logic [CNT_W-1:0]    C_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    C_LAST  = CNT_W'(WORD_W - 1);

  logic [1:0]          r_state;
  logic [2:0]          r_op;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_mc;
  logic [2*WORD_W-1:0] r_acc;
  logic                r_neg;
  logic                r_dz_pend;
  logic                r_done;
  logic [WORD_W-1:0]   r_result;
  logic                r_div_zero;

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [WORD_W-1:0]   w_mag_a;
  logic [WORD_W-1:0]   w_mag_b;
  logic                w_accept;
  logic                w_div_zero;
  logic                w_ovf;
  logic                w_fast;
  logic [WORD_W-1:0]   w_fast_val;
  logic [WORD_W:0]     w_mul_sum;
  logic [2*WORD_W-1:0] w_mul_next;
  logic [WORD_W:0]     w_div_trial;
  logic [2*WORD_W-1:0] w_div_next;
  logic [2*WORD_W-1:0] w_step;
  logic [2*WORD_W-1:0] w_fix_mul;
  logic [WORD_W-1:0]   w_quo_fix;
  logic [WORD_W-1:0]   w_rem_fix;
  logic [WORD_W-1:0]   w_final;

  assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign w_a_neg    = w_a_signed & port_a[WORD_W-1];
  assign w_b_neg    = w_b_signed & port_b[WORD_W-1];
  assign w_mag_a    = w_a_neg ? (~port_a + W_ONE) : port_a;
  assign w_mag_b    = w_b_neg ? (~port_b + W_ONE) : port_b;

  assign w_accept   = (r_state == ST_IDLE) && start && !flush && !r_done;
  assign w_div_zero = (port_b == '0);
  assign w_ovf      = ((op == OP_DIV) || (op == OP_REM)) && (port_a == W_MIN) && (port_b == W_ONES);
  assign w_fast     = op[2] && (w_div_zero || w_ovf);

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_fast_val = '0;
    if (w_div_zero) begin
      w_fast_val = op[1] ? port_a : W_ONES;
    end else begin
      w_fast_val = op[1] ? '0 : W_MIN;
    end
  end

  // Multiply: low half of r_acc is the multiplier, shifted out LSB first.
  assign w_mul_sum  = {1'b0, r_acc[2*WORD_W-1:WORD_W]} + (r_acc[0] ? {1'b0, r_mc} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WORD_W-1:1]};

  // Divide: high half is the partial remainder, low half collects the quotient.
  assign w_div_trial = r_acc[2*WORD_W-1:WORD_W-1] - {1'b0, r_mc};
  assign w_div_next  = w_div_trial[WORD_W] ? {r_acc[2*WORD_W-2:0], 1'b0}
                                           : {w_div_trial[WORD_W-1:0], r_acc[WORD_W-2:0], 1'b1};
  assign w_step      = r_op[2] ? w_div_next : w_mul_next;

  assign w_fix_mul = r_neg ? (~w_step + D_ONE) : w_step;
  assign w_quo_fix = r_neg ? (~w_step[WORD_W-1:0] + W_ONE) : w_step[WORD_W-1:0];
  assign w_rem_fix = r_neg ? (~w_step[2*WORD_W-1:WORD_W] + W_ONE) : w_step[2*WORD_W-1:WORD_W];

  always_comb begin
    w_final = w_rem_fix;
    case (r_op)
      OP_MUL:                       w_final = w_fix_mul[WORD_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_fix_mul[2*WORD_W-1:WORD_W];
      OP_DIV, OP_DIVU:              w_final = w_quo_fix;
      default:                      w_final = w_rem_fix;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_cnt      <= '0;
      r_mc       <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op  <= op;
            r_cnt <= '0;
            if (w_fast) begin
              r_state   <= ST_FINISH;
              r_acc     <= {{WORD_W{1'b0}}, w_fast_val};
              r_dz_pend <= w_div_zero;
              r_neg     <= 1'b0;
            end else begin
              r_state   <= ST_BUSY;
              r_mc      <= w_mag_b;
              r_acc     <= {{WORD_W{1'b0}}, w_mag_a};
              r_dz_pend <= 1'b0;
              r_neg     <= (op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
            end
          end
        end
        ST_BUSY: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + C_ONE;
            if (r_cnt == C_LAST) begin
              r_state <= ST_FINISH;
              r_acc   <= {{WORD_W{1'b0}}, w_final};
            end else begin
              r_acc <= w_step;
            end
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          if (!flush) begin
            r_done     <= 1'b1;
            r_result   <= r_acc[WORD_W-1:0];
            r_div_zero <= r_dz_pend;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == ST_BUSY);
  assign done      = r_done;
  assign result    = r_result;
  assign div_zero  = r_div_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a scoreboard of
// expected {div_zero, result} values.
module tb_muldiv_unit;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic [2:0]  op;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];
  logic [32:0] last_exp;

  muldiv_unit #(.WORD_W(32), .CNT_W(6)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op),
    .port_a(port_a), .port_b(port_b), .flush(flush),
    .busy(busy), .done(done), .result(result), .div_zero(div_zero),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [32:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s;
    logic [63:0] ua, ub, p;
    logic signed [31:0] sa32, sb32, sq;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ub_s = ub;
    sa32 = a;
    sb32 = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (o)
      3'd0: begin p = ua * ub; return {1'b0, p[31:0]}; end
      3'd1: begin p = sa * sb; return {1'b0, p[63:32]}; end
      3'd2: begin p = sa * ub_s; return {1'b0, p[63:32]}; end
      3'd3: begin p = ua * ub; return {1'b0, p[63:32]}; end
      3'd4: begin
        if (b == 0) return {1'b1, 32'hFFFF_FFFF};
        if (ovf) return {1'b0, 32'h8000_0000};
        sq = sa32 / sb32; return {1'b0, sq};
      end
      3'd5: begin
        if (b == 0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, a / b};
      end
      3'd6: begin
        if (b == 0) return {1'b1, a};
        if (ovf) return 33'd0;
        sq = sa32 % sb32; return {1'b0, sq};
      end
      default: begin
        if (b == 0) return {1'b1, a};
        return {1'b0, a % b};
      end
    endcase
  endfunction

  // driver: one operation, hammering start during it when asked
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic dz,
                        input int exp_lat, input int exp_busy, input bit hammer);
    int lat;
    int busy_n;
    bit got;
    logic [32:0] want;
    @(negedge CLK);
    op = o; port_a = a; port_b = b; start = 1'b1;
    exp_q.push_back({dz, res});
    @(posedge CLK); #1;
    start = hammer; op = 3'($urandom_range(0, 7)); port_a = $urandom; port_b = $urandom;
    lat = 0; busy_n = 0; got = 1'b0;
    if (busy) busy_n++;
    while (!got && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (done) begin
        got = 1'b1;
        start = 1'b0;
      end else begin
        if (busy) busy_n++;
        start = hammer && (lat < 28);
        port_a = $urandom; port_b = $urandom;
      end
    end
    start = 1'b0;
    want = exp_q.pop_front();
    last_exp = want;
    check({name, "_done"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    check({name, "_result"}, 64'(result), 64'(want[31:0]));
    check({name, "_div_zero"}, 64'(div_zero), 64'(want[32]));
    @(posedge CLK); #1;
    check({name, "_pulse_end"}, {61'd0, done, busy, dbg_state == 2'd0}, 64'd1);
    check({name, "_held"}, {31'd0, div_zero, result}, {31'd0, want});
  endtask

  task automatic run_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] m;
    bit fast;
    m = ref_model(o, a, b);
    fast = o[2] && ((b == 0) || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    run_op($sformatf("rand_op%0d", o), o, a, b, m[31:0], m[32], fast ? 1 : 33, fast ? 0 : 32, 1'b1);
  endtask

  initial begin
    int dones;
    nRST = 1'b0; start = 1'b0; op = '0; port_a = '0; port_b = '0; flush = 1'b0;
    last_exp = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_state", 64'(dbg_state), 64'd0);
    check("reset_outputs", {60'd0, busy, done, div_zero, result == 32'd0}, 64'd1);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    check("post_reset_idle", {61'd0, busy, done, dbg_state == 2'd0}, 64'd1);

    run_op("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 32, 1'b1);

    // reset in the middle of an operation
    @(negedge CLK);
    op = 3'd1; port_a = 32'h1234_5678; port_b = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    check("rst_mid_busy_before", {62'd0, busy, dbg_state == 2'd1}, 64'd3);
    #2 nRST = 1'b0;
    #1;
    check("rst_mid_async", {62'd0, busy, done}, 64'd0);
    check("rst_mid_result", {31'd0, div_zero, result}, 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done) dones++;
    end
    check("rst_mid_no_done", 64'(dones), 64'd0);

    run_op("mulhu_3x5", 3'd3, 32'd3, 32'd5, 32'h0000_0000, 1'b0, 33, 32, 1'b0);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33, 32, 1'b1);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33, 32, 1'b0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'h0000_000E, 1'b0, 33, 32, 1'b1);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'h0000_0002, 1'b0, 33, 32, 1'b0);
    run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 32, 1'b1);
    run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 32, 1'b0);
    run_op("div_by0", 3'd4, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 0, 1'b1);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1, 0, 1'b1);
    run_op("remu_by0", 3'd7, 32'hCAFE_0001, 32'd0, 32'hCAFE_0001, 1'b1, 1, 0, 1'b0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 0, 1'b0);

    // flush at BUSY cycle 10 with start also high
    @(negedge CLK);
    op = 3'd5; port_a = 32'd1000; port_b = 32'd3; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    flush = 1'b1; start = 1'b1; op = 3'd0; port_a = 32'd9; port_b = 32'd9;
    @(posedge CLK); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_to_idle", {61'd0, busy, done, dbg_state == 2'd0}, 64'd1);
    check("flush_result_kept", {31'd0, div_zero, result}, {31'd0, last_exp});
    dones = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done) dones++;
    end
    check("flush_no_done", 64'(dones), 64'd0);
    run_op("after_flush_remu", 3'd7, 32'd100, 32'd7, 32'h0000_0002, 1'b0, 33, 32, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_model(ro, ra, rb);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
